matmul_operand_sp: RTL and testbench
====================================

MATMUL_OPERAND_SP -- requirements
Module: matmul_operand_sp

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 8, element width; BUS_WIDTH, 16, bus width; ADDR_WIDTH, 32, address width; MAX_DIM = BUS_WIDTH/DATA_WIDTH, derived, not overridable.
REQ-002 SHALL have one clock, clk_i; reset is asynchronous and active-high, rst_i.
REQ-003 SHALL have ports:
- clk_i  in  1  clock
- rst_i  in  1  async active-high reset
- get_matA_i / get_matB_i / get_matC_i  in  1 each  operand fetch requests from matmul_calc_module
- mode_i  in  1  bias enable
- rd_data_o  out  BUS_WIDTH  operand stream
- finished_a_o / finished_b_o / finished_c_o  out  1 each  operand delivered
- enable_w_i  in  1  result write strobe
- address_i  in  ADDR_WIDTH  result address
- data_i  in  BUS_WIDTH  result data
- flags_i  in  BUS_WIDTH  overflow flags
- finish_mul_i  in  1  matmul done pulse
- host_we_i  in  1  host write strobe
- host_addr_i  in  ADDR_WIDTH  host address
- host_data_i  in  BUS_WIDTH  host write data
- host_rd_data_o  out  BUS_WIDTH  host read data
- host_err_o  out  1  host access rejected
- busy_o  out  1  stream or write-back in progress
- flags_o  out  BUS_WIDTH  latched flags

Function
REQ-004 SHALL store A and B as MAX_DIM rows of BUS_WIDTH each, and C as MAX_DIM*MAX_DIM elements of BUS_WIDTH each.
REQ-005 SHALL decode address bits [4:0] as the operand select: 5'b00100 = A, 5'b01000 = B, 5'b10000 = C.
- Index field for A/B: bits [5 +: clog2(MAX_DIM)].
- Index field for C: bits [5 +: 2*clog2(MAX_DIM)].
- Any other select value, or an out-of-range index, is invalid.
REQ-006 SHALL implement an FSM with states IDLE, RD_A, RD_B, RD_C, WAIT_WR; busy_o = (state != IDLE).
REQ-007 SHALL, in IDLE, accept get_matA_i=1 at edge E0: rd_data_o<=A[0], state->RD_A.
REQ-008 SHALL stream one word per edge, with no gaps and no stalls:
- A rows 0..MAX_DIM-1 at edges E0..E(MAX_DIM-1).
- B rows at the next MAX_DIM edges.
- C elements at the next MAX_DIM² edges.
REQ-009 SHALL set each finished flag on the edge that retires the last word of its operand, and hold it high until cleared:
- finished_a_o: set at E(MAX_DIM), together with B[0] driven.
- finished_b_o: set at E(2*MAX_DIM).
- finished_c_o: set at E(2*MAX_DIM+MAX_DIM²); state->WAIT_WR, rd_data_o<=0.
REQ-010 SHALL abort a stream if, in RD_A/RD_B/RD_C, all get_mat*_i are sampled low: state->IDLE, finished_*<=0, rd_data_o<=0.
REQ-011 SHALL, on enable_w_i=1 with select C and a valid index, write C[index]<=data_i at the edge; invalid writes are dropped silently. This applies in any state.
REQ-012 SHALL, on finish_mul_i=1, latch flags_o<={0, flags_i[MAX_DIM²-1:0]} and clear finished_*. From WAIT_WR the state goes to IDLE; in other states only the flags latch occurs.
REQ-013 SHALL accept host writes (A/B/C) only in IDLE. A host write that is rejected (busy or invalid address) pulses host_err_o for one cycle and leaves storage unchanged.
REQ-014 SHALL provide host reads: host_rd_data_o<=addressed word one cycle after host_addr_i; an invalid address returns 0.
REQ-015 SHALL give a calc write priority over a host write to the same C element in the same cycle; the host write is then flagged per REQ-013.
REQ-016 SHALL treat stored words as raw bits; no arithmetic is performed.

Reset
REQ-017 SHALL, on rst_i=1, asynchronously take effect at any time, including mid-stream:
- All outputs <= 0.
- A, B and C storage <= 0.
- State <= IDLE.
REQ-018 SHALL ignore all inputs while rst_i=1.

Configuration
REQ-019 SHALL support macro MATMUL_SP_BIAS_GATE_EN:
- Defined: the C stream delivers zeros when mode_i=0, and stored C when mode_i=1.
- Undefined: mode_i is ignored and stored C is always streamed.

Verification (MAX_DIM=2, BUS_WIDTH=16)
REQ-020 Host loads A={0x0201,0x0403}, B={0x0605,0x0807}, C={1,2,3,4}; assert get_matA_i -> rd_data_o 0x0201,0x0403,0x0605,0x0807,1,2,3,4 on consecutive edges; finished_a/b/c rise at E2/E4/E8.
REQ-021 With the macro defined, mode_i=0, repeat REQ-020 -> C words are 0,0,0,0; undefined -> 1,2,3,4.
REQ-022 enable_w_i with address_i=0x30 (C index 1), data 0x1234 -> host read of C[1] returns 0x1234; address_i=0x14 -> no storage change.
REQ-023 finish_mul_i with flags_i=0xFFFF in WAIT_WR -> flags_o=0x000F, finished_*=0, busy_o=0 on the next cycle.
REQ-024 Drop all get_mat*_i during RD_B -> next edge state IDLE, rd_data_o=0, finished_a_o=0; a host write while busy -> host_err_o=1 pulse.
REQ-025 Assert rst_i mid-RD_C -> all outputs and storage read 0 immediately; a new get_matA_i after release streams zeros.

Source files
------------

// File: rtl/matmul_operand_sp.sv
// Operand scratchpad for the matmul engine: streams A rows, B rows, then C elements, and accepts result/host writes.
// Latency: first operand word one edge after get_matA_i, then one word per edge; host reads return one cycle after the address.
// Backpressure: none; dropping all get_mat*_i aborts a stream. Optional MATMUL_SP_BIAS_GATE_EN gates the C stream with mode_i.
module matmul_operand_sp #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  get_matA_i,
  input  logic                  get_matB_i,
  input  logic                  get_matC_i,
  input  logic                  mode_i,
  output logic [BUS_WIDTH-1:0]  rd_data_o,
  output logic                  finished_a_o,
  output logic                  finished_b_o,
  output logic                  finished_c_o,
  input  logic                  enable_w_i,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic [BUS_WIDTH-1:0]  data_i,
  input  logic [BUS_WIDTH-1:0]  flags_i,
  input  logic                  finish_mul_i,
  input  logic                  host_we_i,
  input  logic [ADDR_WIDTH-1:0] host_addr_i,
  input  logic [BUS_WIDTH-1:0]  host_data_i,
  output logic [BUS_WIDTH-1:0]  host_rd_data_o,
  output logic                  host_err_o,
  output logic                  busy_o,
  output logic [BUS_WIDTH-1:0]  flags_o
);

  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int IDX_W   = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam int CI_W    = 2 * IDX_W;
  localparam int NC      = MAX_DIM * MAX_DIM;
  localparam int CNT_W   = CI_W + 1;
  localparam int XW      = ADDR_WIDTH - 5;

  localparam logic [CNT_W-1:0] DIM_C  = CNT_W'(MAX_DIM);
  localparam logic [CNT_W-1:0] NC_C   = CNT_W'(NC);
  localparam logic [XW-1:0]    LIM_AB = XW'(MAX_DIM);
  localparam logic [XW-1:0]    LIM_C  = XW'(NC);
  localparam logic [4:0]       SEL_A  = 5'b00100;
  localparam logic [4:0]       SEL_B  = 5'b01000;
  localparam logic [4:0]       SEL_C  = 5'b10000;

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, RD_C, WAIT_WR} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [BUS_WIDTH-1:0] rd_nxt, flags_nxt, rd_word;
  logic                 fa_nxt, fb_nxt, fc_nxt;
  logic                 get_any, c_pass;

  logic [BUS_WIDTH-1:0] a_mem [MAX_DIM];
  logic [BUS_WIDTH-1:0] b_mem [MAX_DIM];
  logic [BUS_WIDTH-1:0] c_mem [NC];

  // Whole index field above the select bits, so any upper address bit set makes the index out of range.
  logic [XW-1:0] w_idx, h_idx;
  logic          w_c_ok, calc_wr, h_a_ok, h_b_ok, h_c_ok, h_ok, conflict, host_wr;

  assign w_idx    = address_i[ADDR_WIDTH-1:5];
  assign h_idx    = host_addr_i[ADDR_WIDTH-1:5];
  assign w_c_ok   = (address_i[4:0] == SEL_C) && (w_idx < LIM_C);
  assign calc_wr  = enable_w_i && w_c_ok;
  assign h_a_ok   = (host_addr_i[4:0] == SEL_A) && (h_idx < LIM_AB);
  assign h_b_ok   = (host_addr_i[4:0] == SEL_B) && (h_idx < LIM_AB);
  assign h_c_ok   = (host_addr_i[4:0] == SEL_C) && (h_idx < LIM_C);
  assign h_ok     = h_a_ok || h_b_ok || h_c_ok;
  // A result write from the engine wins over a host write to the same C element.
  assign conflict = calc_wr && h_c_ok && (w_idx[CI_W-1:0] == h_idx[CI_W-1:0]);
  assign host_wr  = host_we_i && (state == IDLE) && h_ok && !conflict;
  assign get_any  = get_matA_i || get_matB_i || get_matC_i;
  assign busy_o   = (state != IDLE);

`ifdef MATMUL_SP_BIAS_GATE_EN
  assign c_pass = mode_i;
`else
  // Without the bias gate mode_i has no effect on the C stream.
  assign c_pass = mode_i | 1'b1;
`endif

  // Next-state, stream word, completion flags and flag latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rd_nxt    = rd_data_o;
    fa_nxt    = finished_a_o;
    fb_nxt    = finished_b_o;
    fc_nxt    = finished_c_o;
    flags_nxt = flags_o;
    case (state)
      IDLE: begin
        if (get_matA_i) begin
          rd_nxt    = a_mem[0];
          cnt_nxt   = CNT_W'(1);
          state_nxt = RD_A;
        end
      end
      RD_A, RD_B, RD_C: begin
        if (!get_any) begin
          state_nxt = IDLE;
          rd_nxt    = '0;
          fa_nxt    = 1'b0;
          fb_nxt    = 1'b0;
          fc_nxt    = 1'b0;
        end else if (state == RD_A) begin
          if (cnt < DIM_C) begin
            rd_nxt  = a_mem[cnt[IDX_W-1:0]];
            cnt_nxt = cnt + CNT_W'(1);
          end else begin
            rd_nxt    = b_mem[0];
            fa_nxt    = 1'b1;
            cnt_nxt   = CNT_W'(1);
            state_nxt = RD_B;
          end
        end else if (state == RD_B) begin
          if (cnt < DIM_C) begin
            rd_nxt  = b_mem[cnt[IDX_W-1:0]];
            cnt_nxt = cnt + CNT_W'(1);
          end else begin
            rd_nxt    = c_pass ? c_mem[0] : '0;
            fb_nxt    = 1'b1;
            cnt_nxt   = CNT_W'(1);
            state_nxt = RD_C;
          end
        end else begin
          if (cnt < NC_C) begin
            rd_nxt  = c_pass ? c_mem[cnt[CI_W-1:0]] : '0;
            cnt_nxt = cnt + CNT_W'(1);
          end else begin
            rd_nxt    = '0;
            fc_nxt    = 1'b1;
            state_nxt = WAIT_WR;
          end
        end
      end
      default: ;
    endcase
    if (finish_mul_i) begin
      for (int i = 0; i < BUS_WIDTH; i++) flags_nxt[i] = (i < NC) ? flags_i[i] : 1'b0;
      if (state == WAIT_WR) begin
        state_nxt = IDLE;
        fa_nxt    = 1'b0;
        fb_nxt    = 1'b0;
        fc_nxt    = 1'b0;
      end
    end
  end

  // State and registered stream outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      rd_data_o    <= '0;
      finished_a_o <= 1'b0;
      finished_b_o <= 1'b0;
      finished_c_o <= 1'b0;
      flags_o      <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      rd_data_o    <= rd_nxt;
      finished_a_o <= fa_nxt;
      finished_b_o <= fb_nxt;
      finished_c_o <= fc_nxt;
      flags_o      <= flags_nxt;
    end
  end

  // Operand storage: engine result writes in any state, host writes only when idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MAX_DIM; i++) begin
        a_mem[i] <= '0;
        b_mem[i] <= '0;
      end
      for (int i = 0; i < NC; i++) c_mem[i] <= '0;
    end else begin
      if (host_wr && h_a_ok) a_mem[h_idx[IDX_W-1:0]] <= host_data_i;
      if (host_wr && h_b_ok) b_mem[h_idx[IDX_W-1:0]] <= host_data_i;
      if (host_wr && h_c_ok) c_mem[h_idx[CI_W-1:0]] <= host_data_i;
      if (calc_wr) c_mem[w_idx[CI_W-1:0]] <= data_i;
    end
  end

  // Host read mux; invalid addresses read as zero.
  always_comb begin
    rd_word = '0;
    if (h_a_ok)      rd_word = a_mem[h_idx[IDX_W-1:0]];
    else if (h_b_ok) rd_word = b_mem[h_idx[IDX_W-1:0]];
    else if (h_c_ok) rd_word = c_mem[h_idx[CI_W-1:0]];
  end

  // Registered host read data and one-cycle reject pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      host_rd_data_o <= '0;
      host_err_o     <= 1'b0;
    end else begin
      host_rd_data_o <= rd_word;
      host_err_o     <= host_we_i && !host_wr;
    end
  end

endmodule

// File: tb/tb_matmul_operand_sp.sv
// Self-checking bench for matmul_operand_sp with MAX_DIM=2, BUS_WIDTH=16.
// Operand stream words are queued from a bench-side storage model and compared edge by edge.
// Follows MATMUL_SP_BIAS_GATE_EN for the expected C stream contents.
module tb_matmul_operand_sp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        get_a = 1'b0, get_b = 1'b0, get_c = 1'b0, mode = 1'b0;
  logic [15:0] rd_data;
  logic        fin_a, fin_b, fin_c;
  logic        en_w = 1'b0;
  logic [31:0] addr_w = '0;
  logic [15:0] data_w = '0, flags_in = '0;
  logic        fin_mul = 1'b0, host_we = 1'b0;
  logic [31:0] host_addr = '0;
  logic [15:0] host_data = '0;
  logic [15:0] host_rdata, flags_out;
  logic        host_err, busy;

  int checks = 0;
  int errors = 0;
  logic [15:0] mA [2];
  logic [15:0] mB [2];
  logic [15:0] mC [4];
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  matmul_operand_sp dut (
    .clk_i(clk), .rst_i(rst),
    .get_matA_i(get_a), .get_matB_i(get_b), .get_matC_i(get_c), .mode_i(mode),
    .rd_data_o(rd_data), .finished_a_o(fin_a), .finished_b_o(fin_b), .finished_c_o(fin_c),
    .enable_w_i(en_w), .address_i(addr_w), .data_i(data_w), .flags_i(flags_in),
    .finish_mul_i(fin_mul), .host_we_i(host_we), .host_addr_i(host_addr),
    .host_data_i(host_data), .host_rd_data_o(host_rdata), .host_err_o(host_err),
    .busy_o(busy), .flags_o(flags_out)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] adr(input int sel, input int idx);
    return 32'((idx << 5) | sel);
  endfunction

  task automatic do_host_wr(input logic [31:0] a, input logic [15:0] d, input logic exp_err, input string tag);
    host_we = 1'b1; host_addr = a; host_data = d;
    tick;
    host_we = 1'b0;
    chk(tag, 16'(host_err), 16'(exp_err));
  endtask

  task automatic do_host_rd(input logic [31:0] a, input logic [15:0] exp, input string tag);
    host_addr = a;
    tick;
    chk(tag, host_rdata, exp);
  endtask

  // Full stream: A rows, B rows, C elements, then the WAIT_WR handoff edge.
  task automatic stream_full(input logic md, input string tag);
    mode = md;
    for (int i = 0; i < 2; i++) exp_q.push_back(mA[i]);
    for (int i = 0; i < 2; i++) exp_q.push_back(mB[i]);
    for (int i = 0; i < 4; i++) begin
`ifdef MATMUL_SP_BIAS_GATE_EN
      exp_q.push_back(md ? mC[i] : 16'h0000);
`else
      exp_q.push_back(mC[i]);
`endif
    end
    get_a = 1'b1;
    tick;
    for (int k = 0; k < 8; k++) begin
      logic [15:0] e;
      if (k > 0) tick;
      e = exp_q.pop_front();
      chk($sformatf("%s_w%0d", tag, k), rd_data, e);
      chk($sformatf("%s_fa%0d", tag, k), 16'(fin_a), 16'(k >= 2));
      chk($sformatf("%s_fb%0d", tag, k), 16'(fin_b), 16'(k >= 4));
      chk($sformatf("%s_fc%0d", tag, k), 16'(fin_c), 16'h0000);
    end
    tick;
    get_a = 1'b0;
    chk({tag, "_fc_end"}, 16'(fin_c), 16'h0001);
    chk({tag, "_rd_end"}, rd_data, 16'h0000);
    chk({tag, "_busy_wait"}, 16'(busy), 16'h0001);
    chk({tag, "_q_empty"}, 16'(exp_q.size()), 16'h0000);
  endtask

  task automatic finish_mul(input logic [15:0] f, input logic [15:0] exp_flags, input string tag);
    flags_in = f; fin_mul = 1'b1;
    tick;
    fin_mul = 1'b0;
    chk({tag, "_flags"}, flags_out, exp_flags);
    chk({tag, "_fin"}, {13'd0, fin_a, fin_b, fin_c}, 16'h0000);
    chk({tag, "_busy"}, 16'(busy), 16'h0000);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin mA[i] = '0; mB[i] = '0; end
    for (int i = 0; i < 4; i++) mC[i] = '0;

    // Reset state
    repeat (3) tick;
    chk("rst_rd", rd_data, 16'h0000);
    chk("rst_busy", 16'(busy), 16'h0000);
    chk("rst_fin", {13'd0, fin_a, fin_b, fin_c}, 16'h0000);
    chk("rst_flags", flags_out, 16'h0000);
    chk("rst_herr", 16'(host_err), 16'h0000);
    chk("rst_hrd", host_rdata, 16'h0000);
    rst = 1'b0;
    tick;

    // Host load
    mA[0] = 16'h0201; mA[1] = 16'h0403; mB[0] = 16'h0605; mB[1] = 16'h0807;
    mC[0] = 16'h0001; mC[1] = 16'h0002; mC[2] = 16'h0003; mC[3] = 16'h0004;
    for (int i = 0; i < 2; i++) do_host_wr(adr(4, i), mA[i], 1'b0, $sformatf("ld_a%0d", i));
    for (int i = 0; i < 2; i++) do_host_wr(adr(8, i), mB[i], 1'b0, $sformatf("ld_b%0d", i));
    for (int i = 0; i < 4; i++) do_host_wr(adr(16, i), mC[i], 1'b0, $sformatf("ld_c%0d", i));
    do_host_rd(adr(4, 1), 16'h0403, "rd_a1");
    do_host_rd(adr(16, 3), 16'h0004, "rd_c3");

    // Streams with bias gate off and on
    stream_full(1'b0, "s_m0");
    finish_mul(16'hFFFF, 16'h000F, "fm1");
    stream_full(1'b1, "s_m1");
    finish_mul(16'h0005, 16'h0005, "fm2");

    // Engine result writes
    en_w = 1'b1; addr_w = 32'h30; data_w = 16'h1234;
    tick;
    en_w = 1'b0;
    mC[1] = 16'h1234;
    do_host_rd(adr(16, 1), 16'h1234, "cw_c1");
    en_w = 1'b1; addr_w = 32'h14; data_w = 16'hBEEF;
    tick;
    en_w = 1'b0;
    for (int i = 0; i < 4; i++) do_host_rd(adr(16, i), mC[i], $sformatf("cw_bad_c%0d", i));
    do_host_rd(adr(4, 0), mA[0], "cw_bad_a0");

    // Same-cycle engine and host write to one C element
    en_w = 1'b1; addr_w = adr(16, 2); data_w = 16'hAAAA;
    host_we = 1'b1; host_addr = adr(16, 2); host_data = 16'h5555;
    tick;
    en_w = 1'b0; host_we = 1'b0;
    chk("conf_err", 16'(host_err), 16'h0001);
    mC[2] = 16'hAAAA;
    do_host_rd(adr(16, 2), 16'hAAAA, "conf_c2");
    chk("conf_err_pulse", 16'(host_err), 16'h0000);

    // Invalid host addresses
    do_host_wr(32'h0000000C, 16'h1111, 1'b1, "bad_sel");
    do_host_wr(adr(4, 2), 16'h2222, 1'b1, "bad_idx");
    do_host_rd(adr(4, 2), 16'h0000, "bad_rd");
    do_host_rd(adr(4, 0), mA[0], "bad_a0_kept");

    // Busy host write, then abort in RD_B
    get_a = 1'b1;
    tick;
    chk("ab_e0", rd_data, mA[0]);
    host_we = 1'b1; host_addr = adr(4, 0); host_data = 16'hDEAD;
    tick;
    host_we = 1'b0;
    chk("ab_busy_err", 16'(host_err), 16'h0001);
    chk("ab_e1", rd_data, mA[1]);
    tick;
    chk("ab_e2", rd_data, mB[0]);
    chk("ab_fa", 16'(fin_a), 16'h0001);
    get_a = 1'b0;
    tick;
    chk("ab_busy", 16'(busy), 16'h0000);
    chk("ab_rd", rd_data, 16'h0000);
    chk("ab_fa_clr", 16'(fin_a), 16'h0000);
    do_host_rd(adr(4, 0), mA[0], "ab_a0_kept");

    // Reset in the middle of the C stream
    mode = 1'b1;
    get_a = 1'b1;
    repeat (5) tick;
    chk("mr_in_c", rd_data, mC[0]);
    #2 rst = 1'b1;
    #1;
    chk("mr_rd", rd_data, 16'h0000);
    chk("mr_busy", 16'(busy), 16'h0000);
    chk("mr_fin", {13'd0, fin_a, fin_b, fin_c}, 16'h0000);
    chk("mr_flags", flags_out, 16'h0000);
    get_a = 1'b0;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin mA[i] = '0; mB[i] = '0; end
    for (int i = 0; i < 4; i++) mC[i] = '0;
    do_host_rd(adr(4, 0), 16'h0000, "mr_a0");
    do_host_rd(adr(16, 1), 16'h0000, "mr_c1");
    stream_full(1'b1, "s_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
